kp_poly_engine: RTL and testbench

Polyphonic, time-multiplexed Karplus-Strong plucked-string engine. It keeps VOICES independent delay lines in one shared inferred RAM and services every voice once per audio sample strobe. For each voice it either writes a noise excitation or writes back the averaging-filtered feedback, then sums all voices into one scaled output sample. It is a drop-in successor to the single-voice string block and feeds the audio output path.

---
 rtl/kp_poly_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_kp_poly_engine.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kp_poly_engine.sv
// kp_poly_engine
// Polyphonic time-multiplexed Karplus-Strong plucked-string engine.
// VOICES delay lines share one inferred RAM addressed {voice, ptr}. On every
// sample_en strobe the engine walks all voices (RD then UPD per voice),
// writes either LFSR noise (fill phase) or the two-tap averaged feedback back
// into each active voice's delay line, sums the voice outputs and emits the
// mix scaled down by VOICES so it can never clip.
//
// Optional feature macro: KP_DECAY_EN
//    defined   : averaged feedback is further attenuated by y - (y >>> DECAY_SHIFT)
//    undefined : plain two-tap average (legacy string behaviour)
//
// Ports
//    a_clk       in   1            sole clock
//    reset       in   1            asynchronous active-high reset
//    sample_en   in   1            one-cycle audio-rate strobe
//    trig_valid  in   1            trigger request
//    trig_ready  out  1            trigger accept, high only while idle
//    trig_voice  in   VW           voice to pluck
//    trig_len    in   DEPTH_LOG2+1 string length in samples, 0 kills the voice
//    out         out  DATA_W       mixed signed output sample
//    out_valid   out  1            one-cycle pulse when out updates
//    overrun     out  1            sticky: sample_en arrived while busy
//
// DATA_W must not exceed 32 (the excitation is the top DATA_W LFSR bits).

module kp_poly_engine #(
   parameter int          DATA_W      = 32,
   parameter int          DEPTH_LOG2  = 12,
   parameter int          VOICES      = 4,
   parameter logic [31:0] SEED        = 32'h1D872B41,
   parameter int          DECAY_SHIFT = 8,
   localparam int         VW          = (VOICES > 1) ? $clog2(VOICES) : 1
) (
   input  logic                     a_clk,
   input  logic                     reset,
   input  logic                     sample_en,
   input  logic                     trig_valid,
   output logic                     trig_ready,
   input  logic [VW-1:0]            trig_voice,
   input  logic [DEPTH_LOG2:0]      trig_len,
   output logic signed [DATA_W-1:0] out,
   output logic                     out_valid,
   output logic                     overrun
);

`ifdef KP_DECAY_EN
   localparam bit DecayEn = 1'b1;
`else
   localparam bit DecayEn = 1'b0;
`endif

   localparam int                  AccW      = DATA_W + VW;
   localparam int                  RamDepth  = VOICES * (2 ** DEPTH_LOG2);
   localparam logic [31:0]         LfsrTaps  = 32'h8020_0003;
   localparam logic [DEPTH_LOG2:0] MinLen    = (DEPTH_LOG2+1)'(4);
   localparam logic [DEPTH_LOG2:0] MaxLen    = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] LenOne    = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);
   localparam logic [VW-1:0]       VoiceOne  = VW'(1);
   localparam logic [VW-1:0]       LastVoice = VW'(VOICES - 1);

   typedef enum logic [1:0] {IDLE, RD, UPD, OUT} state_t;

   state_t                   state_q;
   logic [VW-1:0]            voice_q;
   logic [31:0]              lfsr_q;
   logic signed [AccW-1:0]   acc_q;
   logic signed [DATA_W-1:0] out_q;
   logic                     outValid_q;
   logic                     overrun_q;

   logic                     active_q [VOICES];
   logic [DEPTH_LOG2:0]      len_q    [VOICES];
   logic [DEPTH_LOG2-1:0]    ptr_q    [VOICES];
   logic [DEPTH_LOG2:0]      fill_q   [VOICES];
   logic signed [DATA_W-1:0] prev_q   [VOICES];

   logic [DATA_W-1:0]        mem [RamDepth];
   logic signed [DATA_W-1:0] rdData_q;

   logic                     curActive;
   logic [DEPTH_LOG2:0]      curLen;
   logic [DEPTH_LOG2-1:0]    curPtr;
   logic [DEPTH_LOG2:0]      curFill;
   logic signed [DATA_W-1:0] curPrev;
   logic [VW+DEPTH_LOG2-1:0] ramAddr;
   logic                     inFill;
   logic                     wrEn;
   logic [DATA_W:0]          sum_d;
   logic signed [DATA_W-1:0] avg_d;
   logic signed [DATA_W-1:0] decayed_d;
   logic signed [DATA_W-1:0] feedback_d;
   logic signed [DATA_W-1:0] wrData_d;
   logic signed [DATA_W-1:0] voiceOut_d;
   logic [DEPTH_LOG2-1:0]    ptrNext_d;
   logic [31:0]              lfsr_d;
   logic [DEPTH_LOG2:0]      trigLenClamped_d;

   // Datapath for the voice currently being serviced. The average is formed
   // one bit wider than a sample so the sum of two full-scale values cannot
   // wrap before the halving shift.
   always_comb begin
      curActive  = active_q[voice_q];
      curLen     = len_q[voice_q];
      curPtr     = ptr_q[voice_q];
      curFill    = fill_q[voice_q];
      curPrev    = prev_q[voice_q];
      ramAddr    = {voice_q, curPtr};
      inFill     = (curFill != '0);
      wrEn       = (state_q == UPD) && curActive;

      sum_d      = {rdData_q[DATA_W-1], rdData_q} + {curPrev[DATA_W-1], curPrev};
      avg_d      = sum_d[DATA_W:1];
      decayed_d  = avg_d - (avg_d >>> DECAY_SHIFT);
      feedback_d = DecayEn ? decayed_d : avg_d;

      wrData_d   = inFill ? lfsr_q[31 -: DATA_W] : feedback_d;
      voiceOut_d = curActive ? wrData_d : '0;

      ptrNext_d  = ({1'b0, curPtr} == (curLen - LenOne)) ? '0 : (curPtr + PtrOne);
      lfsr_d     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);

      if (trig_len < MinLen) begin
         trigLenClamped_d = MinLen;
      end else if (trig_len > MaxLen) begin
         trigLenClamped_d = MaxLen;
      end else begin
         trigLenClamped_d = trig_len;
      end
   end

   // Shared delay-line RAM: registered read issued in RD, write-back in UPD.
   // Contents deliberately survive reset; every voice refills before reading.
   always_ff @(posedge a_clk) begin
      if (state_q == RD) begin
         rdData_q <= mem[ramAddr];
      end
      if (wrEn) begin
         mem[ramAddr] <= wrData_d;
      end
   end

   // Scan FSM with all per-voice state. Triggers are only accepted while idle,
   // so they never race the UPD write-back of the same voice; a trigger that
   // coincides with sample_en lands before RD and its fill starts this scan.
   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         voice_q    <= '0;
         lfsr_q     <= SEED;
         acc_q      <= '0;
         out_q      <= '0;
         outValid_q <= 1'b0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < VOICES; i++) begin
            active_q[i] <= 1'b0;
            len_q[i]    <= MinLen;
            ptr_q[i]    <= '0;
            fill_q[i]   <= '0;
            prev_q[i]   <= '0;
         end
      end else begin
         outValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trig_valid) begin
                  if (trig_len == '0) begin
                     active_q[trig_voice] <= 1'b0;
                  end else begin
                     active_q[trig_voice] <= 1'b1;
                     len_q[trig_voice]    <= trigLenClamped_d;
                     fill_q[trig_voice]   <= trigLenClamped_d;
                     ptr_q[trig_voice]    <= '0;
                     prev_q[trig_voice]   <= '0;
                  end
               end
               if (sample_en) begin
                  state_q <= RD;
                  voice_q <= '0;
                  acc_q   <= '0;
               end
            end
            RD: begin
               state_q <= UPD;
            end
            UPD: begin
               if (curActive) begin
                  ptr_q[voice_q] <= ptrNext_d;
                  if (inFill) begin
                     fill_q[voice_q] <= curFill - LenOne;
                     prev_q[voice_q] <= '0;
                     lfsr_q          <= lfsr_d;
                  end else begin
                     prev_q[voice_q] <= rdData_q;
                  end
               end
               acc_q <= acc_q + {{VW{voiceOut_d[DATA_W-1]}}, voiceOut_d};
               if (voice_q == LastVoice) begin
                  state_q <= OUT;
               end else begin
                  voice_q <= voice_q + VoiceOne;
                  state_q <= RD;
               end
            end
            OUT: begin
               // Dropping the low VW bits is the arithmetic divide-by-VOICES.
               out_q      <= acc_q[AccW-1:VW];
               outValid_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         if (sample_en && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign trig_ready = (state_q == IDLE);
   assign out        = out_q;
   assign out_valid  = outValid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_kp_poly_engine.sv
// tb_kp_poly_engine
// Self-checking bench for kp_poly_engine at default parameters (VOICES = 4).
// Directed clamp vectors come from a local table with hand-derived expected
// periods; kill/retrigger, overrun and mid-scan reset are hand sequences; the
// four-voice mix is compared against a sample-level behavioural model.

module tb_kp_poly_engine;

   logic               a_clk = 1'b0;
   logic               reset;
   logic               sample_en;
   logic               trig_valid;
   logic               trig_ready;
   logic [1:0]         trig_voice;
   logic [12:0]        trig_len;
   logic signed [31:0] dutOut;
   logic               out_valid;
   logic               overrun;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] Seed = 32'h1D872B41;

   kp_poly_engine dut (
      .a_clk      (a_clk),
      .reset      (reset),
      .sample_en  (sample_en),
      .trig_valid (trig_valid),
      .trig_ready (trig_ready),
      .trig_voice (trig_voice),
      .trig_len   (trig_len),
      .out        (dutOut),
      .out_valid  (out_valid),
      .overrun    (overrun)
   );

   // 100 MHz free-running clock
   always #5 a_clk = ~a_clk;

   // Behavioural model state, one strobe at a time
   int                 mActive [4];
   int                 mLen    [4];
   int                 mPtr    [4];
   int                 mFill   [4];
   logic signed [31:0] mPrev   [4];
   logic [31:0]        mLfsr;
   logic [31:0]        mMem    [16384];
   logic signed [31:0] mExp;
   logic signed [31:0] noise   [128];

   typedef struct {
      logic [1:0]  voice;
      logic [12:0] trigLen;
      int          expLen;
   } clampVec_t;

   function automatic logic [31:0] lfsrNext(input logic [31:0] x);
      return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Two-tap average at 33 bits, with optional decay
   function automatic logic signed [31:0] filt(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
      logic signed [32:0] s;
      logic signed [31:0] y;
      s = {a[31], a} + {b[31], b};
      y = s >>> 1;
`ifdef KP_DECAY_EN
      y = y - (y >>> 8);
`endif
      return y;
   endfunction

   // Single active voice: mix is voice output divided by 4
   function automatic logic signed [31:0] solo(input logic signed [31:0] x);
      return x >>> 2;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int v = 0; v < 4; v++) begin
         mActive[v] = 0;
         mLen[v]    = 4;
         mPtr[v]    = 0;
         mFill[v]   = 0;
         mPrev[v]   = '0;
      end
      mLfsr = Seed;
   endtask

   task automatic modelTrigger(input int v, input int len);
      int l;
      if (len == 0) begin
         mActive[v] = 0;
      end else begin
         l = (len < 4) ? 4 : ((len > 4096) ? 4096 : len);
         mActive[v] = 1;
         mLen[v]    = l;
         mFill[v]   = l;
         mPtr[v]    = 0;
         mPrev[v]   = '0;
      end
   endtask

   task automatic modelStrobe();
      logic signed [33:0] acc;
      logic signed [33:0] sh;
      logic signed [31:0] vo;
      logic signed [31:0] cur;
      int addr;
      acc = '0;
      for (int v = 0; v < 4; v++) begin
         vo = '0;
         if (mActive[v] != 0) begin
            addr = v * 4096 + mPtr[v];
            if (mFill[v] > 0) begin
               vo = mLfsr;
               mLfsr = lfsrNext(mLfsr);
               mFill[v]--;
               mPrev[v] = '0;
            end else begin
               cur = mMem[addr];
               vo = filt(cur, mPrev[v]);
               mPrev[v] = cur;
            end
            mMem[addr] = vo;
            mPtr[v] = (mPtr[v] == mLen[v] - 1) ? 0 : mPtr[v] + 1;
         end
         acc = acc + 34'(vo);
      end
      sh = acc >>> 2;
      mExp = sh[31:0];
   endtask

   task automatic doReset();
      sample_en  = 1'b0;
      trig_valid = 1'b0;
      trig_voice = '0;
      trig_len   = '0;
      reset      = 1'b1;
      @(posedge a_clk);
      #1;
      reset = 1'b0;
      modelReset();
   endtask

   // Offer a trigger for one IDLE cycle (caller guarantees IDLE)
   task automatic applyTrigger(input logic [1:0] v, input logic [12:0] len);
      trig_valid = 1'b1;
      trig_voice = v;
      trig_len   = len;
      modelTrigger(int'(v), int'(len));
      @(posedge a_clk);
      #1;
      trig_valid = 1'b0;
   endtask

   // One strobe, optionally with a coincident trigger; waits (bounded) for out_valid
   task automatic applyStimulus(input logic doTrig, input logic [1:0] v, input logic [12:0] len,
                                output logic signed [31:0] outVal);
      int cnt;
      sample_en  = 1'b1;
      trig_valid = doTrig;
      trig_voice = v;
      trig_len   = len;
      if (doTrig) modelTrigger(int'(v), int'(len));
      modelStrobe();
      @(posedge a_clk);
      #1;
      sample_en  = 1'b0;
      trig_valid = 1'b0;
      checkOutput("trig_ready_busy", 64'(trig_ready), 64'(0));
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(posedge a_clk);
         #1;
         cnt++;
      end
      checkOutput("latency", 64'(cnt), 64'(9));
      outVal = dutOut;
   endtask

   initial begin
      clampVec_t          vecs [5];
      logic signed [31:0] o;
      logic [31:0]        s;
      int cyc, ovCount, ovCyc, accCyc;
      logic accNow;
      logic signed [31:0] ovOut;

      vecs[0] = '{2'd1, 13'd100, 100};
      vecs[1] = '{2'd2, 13'd2,   4};
      vecs[2] = '{2'd3, 13'd3,   4};
      vecs[3] = '{2'd0, 13'd4,   4};
      vecs[4] = '{2'd1, 13'd7,   7};

      s = Seed;
      for (int i = 0; i < 128; i++) begin
         noise[i] = s;
         s = lfsrNext(s);
      end

      // Reset state and an empty scan
      doReset();
      checkOutput("rst_out", 64'(dutOut), 64'(0));
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_trig_ready", 64'(trig_ready), 64'(1));
      checkOutput("rst_overrun", 64'(overrun), 64'(0));
      applyStimulus(1'b0, 2'd0, 13'd0, o);
      checkOutput("empty_out", 64'(o), 64'(0));
      checkOutput("empty_ready", 64'(trig_ready), 64'(1));
      checkOutput("empty_overrun", 64'(overrun), 64'(0));

      // Clamp / period table: fill with noise, then first two feedback samples
      for (int r = 0; r < 5; r++) begin
         doReset();
         applyStimulus(1'b1, vecs[r].voice, vecs[r].trigLen, o);
         checkOutput("fill_first", 64'(o), 64'(solo(noise[0])));
         for (int k = 1; k < vecs[r].expLen; k++) begin
            applyStimulus(1'b0, 2'd0, 13'd0, o);
            checkOutput("fill", 64'(o), 64'(solo(noise[k])));
         end
         applyStimulus(1'b0, 2'd0, 13'd0, o);
         checkOutput("fb_first", 64'(o), 64'(solo(filt(noise[0], 32'sd0))));
         applyStimulus(1'b0, 2'd0, 13'd0, o);
         checkOutput("fb_second", 64'(o), 64'(solo(filt(noise[1], noise[0]))));
      end

      // Kill and retrigger with LFSR continuity
      doReset();
      applyStimulus(1'b1, 2'd0, 13'd50, o);
      checkOutput("kill_fill0", 64'(o), 64'(solo(noise[0])));
      for (int k = 1; k < 5; k++) begin
         applyStimulus(1'b0, 2'd0, 13'd0, o);
         checkOutput("kill_fill", 64'(o), 64'(solo(noise[k])));
      end
      applyTrigger(2'd0, 13'd0);
      applyStimulus(1'b0, 2'd0, 13'd0, o);
      checkOutput("killed", 64'(o), 64'(0));
      applyStimulus(1'b0, 2'd0, 13'd0, o);
      checkOutput("killed2", 64'(o), 64'(0));
      applyTrigger(2'd0, 13'd50);
      applyStimulus(1'b0, 2'd0, 13'd0, o);
      checkOutput("retrig0", 64'(o), 64'(solo(noise[5])));
      applyStimulus(1'b0, 2'd0, 13'd0, o);
      checkOutput("retrig1", 64'(o), 64'(solo(noise[6])));

      // Overrun: strobes at T and T+5, trigger offered at T+3
      doReset();
      sample_en = 1'b1;
      @(posedge a_clk);
      #1;
      sample_en = 1'b0;
      cyc = 1;
      ovCount = 0;
      ovCyc = -1;
      accCyc = -1;
      ovOut = 32'sd1;
      while (cyc < 16) begin
         if (cyc == 3) begin
            trig_valid = 1'b1;
            trig_voice = 2'd2;
            trig_len   = 13'd10;
            checkOutput("stall_ready", 64'(trig_ready), 64'(0));
         end
         if (cyc == 5) sample_en = 1'b1;
         if (out_valid) begin
            ovCount++;
            ovCyc = cyc;
            ovOut = dutOut;
         end
         accNow = trig_valid && trig_ready;
         if (accNow && accCyc < 0) begin
            accCyc = cyc;
            modelTrigger(2, 10);
         end
         @(posedge a_clk);
         #1;
         cyc++;
         sample_en = 1'b0;
         if (accNow) trig_valid = 1'b0;
      end
      trig_valid = 1'b0;
      checkOutput("ovr_pulses", 64'(ovCount), 64'(1));
      checkOutput("ovr_valid_cycle", 64'(ovCyc), 64'(10));
      checkOutput("ovr_out", 64'(ovOut), 64'(0));
      checkOutput("ovr_accept_cycle", 64'(accCyc), 64'(10));
      checkOutput("ovr_flag", 64'(overrun), 64'(1));
      applyStimulus(1'b0, 2'd0, 13'd0, o);
      checkOutput("ovr_post_fill", 64'(o), 64'(solo(noise[0])));
      checkOutput("ovr_sticky", 64'(overrun), 64'(1));

      // Reset asserted mid-scan, between clock edges
      sample_en = 1'b1;
      @(posedge a_clk);
      #1;
      sample_en = 1'b0;
      @(posedge a_clk);
      #1;
      @(posedge a_clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midrst_ready", 64'(trig_ready), 64'(1));
      checkOutput("midrst_overrun", 64'(overrun), 64'(0));
      checkOutput("midrst_out", 64'(dutOut), 64'(0));
      checkOutput("midrst_valid", 64'(out_valid), 64'(0));
      @(posedge a_clk);
      #1;
      reset = 1'b0;
      modelReset();
      applyStimulus(1'b0, 2'd0, 13'd0, o);
      checkOutput("midrst_scan", 64'(o), 64'(0));

      // Four-voice mix against the model; voice 3 clamps 5000 to 4096 and wraps
      doReset();
      applyTrigger(2'd0, 13'd4);
      applyTrigger(2'd1, 13'd97);
      applyTrigger(2'd2, 13'd1000);
      applyTrigger(2'd3, 13'd5000);
      for (int n = 0; n < 4200; n++) begin
         applyStimulus(1'b0, 2'd0, 13'd0, o);
         checkOutput("mix", 64'(o), 64'(mExp));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
